// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the JESD204 TPL DAC start/stop sequencer.
// The regmap imports the same encodings to decode the status field.
package ad_ip_jesd204_tpl_dac_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] DAC_ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] DAC_ST_ARMED = 3'd1;
   localparam logic [STATE_W-1:0] DAC_ST_SYNC  = 3'd2;
   localparam logic [STATE_W-1:0] DAC_ST_PRIME = 3'd3;
   localparam logic [STATE_W-1:0] DAC_ST_RUN   = 3'd4;
   localparam logic [STATE_W-1:0] DAC_ST_HALT  = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = DAC_ST_IDLE,
      S_ARMED = DAC_ST_ARMED,
      S_SYNC  = DAC_ST_SYNC,
      S_PRIME = DAC_ST_PRIME,
      S_RUN   = DAC_ST_RUN,
      S_HALT  = DAC_ST_HALT
   } dac_state_e;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Start/stop sequencer for the JESD204 TPL DAC datapath (link_clk domain).
// Turns a software arm into one aligned dac_sync pulse (optionally qualified
// by an external sync rising edge), primes the pipeline, then opens the
// transmit gate and supervises link_ready and DMA underflow.
//
// Ports:
//   clk, reset           link clock, synchronous active-high reset
//   arm, stop            single-cycle requests from the regmap
//   ext_sync_en          1 = wait for ext_sync_in rising edge in ARMED
//   ext_sync_in          external sync, already in the clk domain
//   link_ready           JESD link ready
//   dac_dunf             DMA underflow, one sample per cycle
//   dac_sync             one-cycle alignment pulse to the core
//   tx_enable            transmit gate; 0 forces zero data on the link
//   state                current FSM state for status readback
//   link_lost            sticky link loss flag, cleared by an accepted arm
//   unf_count            saturating count of underflow cycles seen in RUN
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | gate closed, waiting for arm
// ARMED | waiting for link_ready (and ext sync edge if enabled)
// SYNC  | one cycle, dac_sync asserted, prime counter loaded
// PRIME | pipeline filling, counting down to RUN
// RUN   | gate open, underflow supervision active
// HALT  | gate closed after persistent underflow, waiting arm/stop
module ad_ip_jesd204_tpl_dac_start_ctrl
   import ad_ip_jesd204_tpl_dac_pkg::*;
#(
   parameter int PRIME_CYCLES    = 4,
   parameter int UNF_LIMIT       = 8,
   parameter int UNF_COUNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       ext_sync_en,
   input  logic                       ext_sync_in,
   input  logic                       link_ready,
   input  logic                       dac_dunf,
   output logic                       dac_sync,
   output logic                       tx_enable,
   output logic [STATE_W-1:0]         state,
   output logic                       link_lost,
   output logic [UNF_COUNT_WIDTH-1:0] unf_count
);

   localparam logic [7:0] PRIME_LOAD = 8'(PRIME_CYCLES - 1);
   localparam logic [7:0] UNF_LAST   = 8'(UNF_LIMIT - 1);

   dac_state_e                 state_q;
   dac_state_e                 state_d;
   logic                       ext_sync_q;
   logic [7:0]                 prime_cnt;
   logic [7:0]                 unf_run_cnt;
   logic [UNF_COUNT_WIDTH-1:0] unf_count_q;
   logic                       link_lost_q;

   logic sync_rise;
   logic link_drop;
   logic arm_accept;

   assign sync_rise  = ext_sync_in & ~ext_sync_q;
   assign link_drop  = ~link_ready & ((state_q == S_PRIME) | (state_q == S_RUN));
   // A simultaneous stop wins, so the arm must not clear the status either.
   assign arm_accept = arm & ~stop & ((state_q == S_IDLE) | (state_q == S_HALT));

   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = S_IDLE;
      end else if (link_drop) begin
         state_d = S_IDLE;
      end else if (arm_accept) begin
         state_d = S_ARMED;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_ARMED: if (link_ready && (!ext_sync_en || sync_rise)) state_d = S_SYNC;
            S_SYNC:  state_d = S_PRIME;
            S_PRIME: if (prime_cnt == 8'd0) state_d = S_RUN;
            S_RUN:   if (dac_dunf && (unf_run_cnt == UNF_LAST)) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ext_sync_q  <= 1'b0;
         prime_cnt   <= 8'd0;
         unf_run_cnt <= 8'd0;
         unf_count_q <= '0;
         link_lost_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Updated in every state so a stale edge from before ARMED is ignored.
         ext_sync_q <= ext_sync_in;

         if (state_q == S_SYNC) begin
            prime_cnt <= PRIME_LOAD;
         end else if ((state_q == S_PRIME) && (prime_cnt != 8'd0)) begin
            prime_cnt <= prime_cnt - 8'd1;
         end

         // Run length of consecutive underflows; leaving RUN resets it, which
         // also covers the clear on a re-arm from HALT.
         if ((state_q == S_RUN) && dac_dunf) begin
            unf_run_cnt <= unf_run_cnt + 8'd1;
         end else begin
            unf_run_cnt <= 8'd0;
         end

         if (arm_accept) begin
            unf_count_q <= '0;
         end else if ((state_q == S_RUN) && dac_dunf && (unf_count_q != '1)) begin
            unf_count_q <= unf_count_q + 1'b1;
         end

         if (arm_accept) begin
            link_lost_q <= 1'b0;
         end else if (link_drop && !stop) begin
            link_lost_q <= 1'b1;
         end
      end
   end

   assign state     = state_q;
   assign dac_sync  = (state_q == S_SYNC);
   assign tx_enable = (state_q == S_RUN);
   assign link_lost = link_lost_q;
   assign unf_count = unf_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Directed bench: one instance with default parameters for sequencing,
// priority, link loss and underflow; a second with UNF_LIMIT=255 for the
// unf_count saturation run.
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

   logic        clk = 1'b0;
   logic        reset, arm, stop, ext_sync_en, ext_sync_in, link_ready, dac_dunf;
   logic        dac_sync, tx_enable, link_lost;
   logic [2:0]  state;
   logic [15:0] unf_count;

   logic        reset2, arm2, dunf2;
   logic        dac_sync2, tx_enable2, link_lost2;
   logic [2:0]  state2;
   logic [15:0] unf_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ad_ip_jesd204_tpl_dac_start_ctrl #(
      .PRIME_CYCLES(4), .UNF_LIMIT(8), .UNF_COUNT_WIDTH(16)
   ) dut (
      .clk(clk), .reset(reset), .arm(arm), .stop(stop),
      .ext_sync_en(ext_sync_en), .ext_sync_in(ext_sync_in),
      .link_ready(link_ready), .dac_dunf(dac_dunf),
      .dac_sync(dac_sync), .tx_enable(tx_enable), .state(state),
      .link_lost(link_lost), .unf_count(unf_count)
   );

   ad_ip_jesd204_tpl_dac_start_ctrl #(
      .PRIME_CYCLES(4), .UNF_LIMIT(255), .UNF_COUNT_WIDTH(16)
   ) dut_sat (
      .clk(clk), .reset(reset2), .arm(arm2), .stop(1'b0),
      .ext_sync_en(1'b0), .ext_sync_in(1'b0),
      .link_ready(1'b1), .dac_dunf(dunf2),
      .dac_sync(dac_sync2), .tx_enable(tx_enable2), .state(state2),
      .link_lost(link_lost2), .unf_count(unf_count2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // state, dac_sync, tx_enable in one go
   task automatic chk_st(input string tag, input logic [2:0] st, input logic sy, input logic tx);
      chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
      chk({tag, ".dac_sync"}, {31'd0, dac_sync}, {31'd0, sy});
      chk({tag, ".tx_enable"}, {31'd0, tx_enable}, {31'd0, tx});
   endtask

   // arm with ext_sync_en=0 and link up: ARMED, SYNC, 4x PRIME, RUN
   task automatic start_to_run(input string tag);
      arm = 1'b1; step(); arm = 1'b0;
      chk_st({tag, ".armed"}, 3'd1, 1'b0, 1'b0);
      step(); chk_st({tag, ".sync"}, 3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(); chk_st({tag, ".prime"}, 3'd3, 1'b0, 1'b0);
      end
      step(); chk_st({tag, ".run"}, 3'd4, 1'b0, 1'b1);
   endtask

   initial begin
      int remaining;
      int chunk;
      int budget;

      reset = 1'b1; arm = 1'b0; stop = 1'b0; ext_sync_en = 1'b0;
      ext_sync_in = 1'b0; link_ready = 1'b1; dac_dunf = 1'b0;
      reset2 = 1'b1; arm2 = 1'b0; dunf2 = 1'b0;
      step(); step();
      chk_st("reset", 3'd0, 1'b0, 1'b0);
      chk("reset.link_lost", {31'd0, link_lost}, 32'd0);
      chk("reset.unf_count", {16'd0, unf_count}, 32'd0);
      reset = 1'b0; reset2 = 1'b0;
      step(); step();
      chk_st("idle", 3'd0, 1'b0, 1'b0);

      // Basic start
      start_to_run("basic");
      arm = 1'b1; step(); arm = 1'b0;
      chk_st("arm_in_run", 3'd4, 1'b0, 1'b1);

      // Underflow: 7 ones, a zero, 8 ones
      for (int i = 0; i < 7; i++) begin
         dac_dunf = 1'b1; step(); chk_st("unf.run7", 3'd4, 1'b0, 1'b1);
      end
      dac_dunf = 1'b0; step();
      chk_st("unf.gap", 3'd4, 1'b0, 1'b1);
      chk("unf.count7", {16'd0, unf_count}, 32'd7);
      for (int i = 0; i < 7; i++) begin
         dac_dunf = 1'b1; step(); chk_st("unf.run8", 3'd4, 1'b0, 1'b1);
      end
      dac_dunf = 1'b1; step(); dac_dunf = 1'b0;
      chk_st("unf.halt", 3'd5, 1'b0, 1'b0);
      chk("unf.count15", {16'd0, unf_count}, 32'd15);
      step();
      chk_st("unf.halt_hold", 3'd5, 1'b0, 1'b0);
      arm = 1'b1; step(); arm = 1'b0;
      chk_st("unf.rearm", 3'd1, 1'b0, 1'b0);
      chk("unf.cleared", {16'd0, unf_count}, 32'd0);
      stop = 1'b1; step(); stop = 1'b0;
      chk_st("stop_armed", 3'd0, 1'b0, 1'b0);

      // stop + arm together in IDLE
      stop = 1'b1; arm = 1'b1; step(); stop = 1'b0; arm = 1'b0;
      chk_st("prio.idle", 3'd0, 1'b0, 1'b0);

      // External sync: level held high before arm must not count as an edge
      ext_sync_en = 1'b1; ext_sync_in = 1'b1;
      step(); step();
      arm = 1'b1; step(); arm = 1'b0;
      chk_st("ext.armed", 3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(); chk_st("ext.hold_high", 3'd1, 1'b0, 1'b0);
      end
      ext_sync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_st("ext.low", 3'd1, 1'b0, 1'b0);
      end
      ext_sync_in = 1'b1; step();
      chk_st("ext.sync", 3'd2, 1'b1, 1'b0);
      ext_sync_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); chk_st("ext.prime", 3'd3, 1'b0, 1'b0);
      end
      step(); chk_st("ext.run", 3'd4, 1'b0, 1'b1);
      ext_sync_in = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      chk_st("ext.stop", 3'd0, 1'b0, 1'b0);

      // Link loss during PRIME
      arm = 1'b1; step(); arm = 1'b0;
      step(); chk_st("ll.sync", 3'd2, 1'b1, 1'b0);
      step(); chk_st("ll.prime", 3'd3, 1'b0, 1'b0);
      link_ready = 1'b0; step(); link_ready = 1'b1;
      chk_st("ll.idle", 3'd0, 1'b0, 1'b0);
      chk("ll.lost", {31'd0, link_lost}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         step(); chk_st("ll.stay_idle", 3'd0, 1'b0, 1'b0);
      end
      chk("ll.sticky", {31'd0, link_lost}, 32'd1);
      arm = 1'b1; step(); arm = 1'b0;
      chk_st("ll.rearm", 3'd1, 1'b0, 1'b0);
      chk("ll.cleared", {31'd0, link_lost}, 32'd0);
      link_ready = 1'b0;
      step(); chk_st("ll.armed_wait", 3'd1, 1'b0, 1'b0);
      step(); chk_st("ll.armed_wait2", 3'd1, 1'b0, 1'b0);
      link_ready = 1'b1;
      step(); chk_st("ll.sync2", 3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      step(); chk_st("ll.run", 3'd4, 1'b0, 1'b1);
      chk("ll.still_clear", {31'd0, link_lost}, 32'd0);

      // Reach HALT, then stop + arm together
      dac_dunf = 1'b1;
      for (int i = 0; i < 8; i++) step();
      dac_dunf = 1'b0;
      chk_st("prio.halt", 3'd5, 1'b0, 1'b0);
      chk("prio.halt_cnt", {16'd0, unf_count}, 32'd8);
      stop = 1'b1; arm = 1'b1; step(); stop = 1'b0; arm = 1'b0;
      chk_st("prio.halt_stop", 3'd0, 1'b0, 1'b0);
      chk("prio.arm_dropped", {16'd0, unf_count}, 32'd8);

      // Mid-run reset
      start_to_run("rst");
      chk("rst.cnt_cleared", {16'd0, unf_count}, 32'd0);
      dac_dunf = 1'b1;
      for (int i = 0; i < 3; i++) step();
      dac_dunf = 1'b0;
      chk("rst.cnt3", {16'd0, unf_count}, 32'd3);
      reset = 1'b1; step(); reset = 1'b0;
      chk_st("rst.after", 3'd0, 1'b0, 1'b0);
      chk("rst.unf", {16'd0, unf_count}, 32'd0);

      // Saturation on the UNF_LIMIT=255 instance
      arm2 = 1'b1; step(); arm2 = 1'b0;
      budget = 20;
      while (state2 != 3'd4 && budget > 0) begin
         step(); budget--;
      end
      chk("sat.reached_run", {29'd0, state2}, 32'd4);
      remaining = 65540;
      while (remaining > 0) begin
         chunk = (remaining > 200) ? 200 : remaining;
         dunf2 = 1'b1;
         for (int i = 0; i < chunk; i++) step();
         dunf2 = 1'b0;
         step();
         remaining -= chunk;
      end
      chk("sat.state", {29'd0, state2}, 32'd4);
      chk("sat.tx", {31'd0, tx_enable2}, 32'd1);
      chk("sat.count", {16'd0, unf_count2}, 32'd65535);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_start_ctrl.md
# ad_ip_jesd204_tpl_dac_start_ctrl

Start/stop sequencer for the JESD204 TPL DAC datapath, running in the `link_clk` domain between the regmap and the TPL core. It turns a software arm request into a single aligned `dac_sync` pulse, optionally qualified by an external sync edge. After a fixed pipeline-prime interval it opens the transmit gate, then supervises `link_ready` and DMA underflow. On a stop, link loss or a persistent underflow it closes the gate so the link carries zeros instead of stale samples.

## Interface
Parameters:
- `PRIME_CYCLES`, 4: cycles between the `dac_sync` pulse and opening the gate; legal range 1..255.
- `UNF_LIMIT`, 8: consecutive `dac_dunf` cycles in RUN that force HALT; legal range 1..255.
- `UNF_COUNT_WIDTH`, 16: width of the underflow statistics counter.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: `link_clk` (line-rate/40).
- `reset` in 1: synchronous, active-high.
- `arm` in 1: single-cycle start request from the regmap.
- `stop` in 1: single-cycle stop request from the regmap.
- `ext_sync_en` in 1: level; 1 = wait for an `ext_sync_in` rising edge before syncing.
- `ext_sync_in` in 1: external sync, already synchronised to `clk`.
- `link_ready` in 1: JESD link ready.
- `dac_dunf` in 1: DMA underflow, level per cycle.
- `dac_sync` out 1: one-cycle pulse to the core (DDS phase reset / channel alignment).
- `tx_enable` out 1: gate; 0 forces `link_data` to zero in the core.
- `state` out 3: current FSM state, for the regmap.
- `link_lost` out 1: sticky; set on `link_ready` loss in PRIME or RUN, cleared by an accepted `arm`.
- `unf_count` out `UNF_COUNT_WIDTH`: saturating count of `dac_dunf` cycles seen in RUN.

## Operation
- States and encoding: IDLE=0, ARMED=1, SYNC=2, PRIME=3, RUN=4, HALT=5. Codes 6 and 7 are unreachable and fall to IDLE.
- Transition priority within a cycle: `reset` > `stop` > link loss > `arm` > other conditions.
- IDLE:
  - `arm` → ARMED.
  - An accepted `arm` clears `link_lost` and `unf_count` in the same edge.
- ARMED:
  - Stay while `link_ready`=0.
  - If `ext_sync_en`=0 → SYNC.
  - Otherwise → SYNC on an `ext_sync_in` rising edge, i.e. current sample 1 and previous registered sample 0.
  - The edge register updates in every state, so an edge that occurred before ARMED is not honoured.
- SYNC: lasts exactly one cycle; `dac_sync`=1; prime counter loads `PRIME_CYCLES-1`; → PRIME.
- PRIME:
  - Counter decrements each cycle; at 0 → RUN.
  - `link_ready`=0 → IDLE and set `link_lost`.
- RUN:
  - `tx_enable`=1.
  - Each `dac_dunf`=1 cycle increments `unf_count`, saturating at all-ones.
  - A consecutive-underflow counter increments on each `dac_dunf`=1 cycle and clears on any `dac_dunf`=0 cycle. When it reaches `UNF_LIMIT` → HALT.
  - `link_ready`=0 → IDLE and set `link_lost`.
- HALT:
  - `tx_enable`=0.
  - `arm` → ARMED, clearing the counters and `link_lost` as in IDLE.
  - `stop` → IDLE.
- `stop` in any state → IDLE. A `stop` and an `arm` in the same cycle yield IDLE; the `arm` is dropped.
- `arm` in ARMED, SYNC, PRIME or RUN is ignored.
- `ext_sync_en` is sampled only in ARMED; changing it elsewhere has no effect.

## Timing
- Reset values: state=IDLE, `dac_sync`=0, `tx_enable`=0, `link_lost`=0, `unf_count`=0; internal counters 0 and edge register 0.
- All outputs are registered, or decoded from the state register only; there are no combinational input-to-output paths.
- `arm` at edge t, with `link_ready`=1 and `ext_sync_en`=0:
  - ARMED at t+1.
  - SYNC at t+2, with `dac_sync` high during the t+2 cycle.
  - RUN from t+3+`PRIME_CYCLES`.
- With `ext_sync_en`=1, an `ext_sync_in` rising edge sampled in ARMED at edge e gives `dac_sync` high in the cycle after e.
- `tx_enable` drops on the same edge that leaves RUN.
- `unf_count` reflects a `dac_dunf` sample one cycle later.
- A mid-operation `reset` returns to the reset values on the next edge, regardless of state.

## Structure
- Package `ad_ip_jesd204_tpl_dac_pkg` holds the state encodings (3-bit localparams) and the 3-bit state width, shared with the regmap's status decode.
- No sub-module; the rising-edge detector and both counters are inline.
- The core instantiates this block between `i_regmap` (`arm`, `stop`, `ext_sync_en`, status) and `i_core` (`dac_sync`, `tx_enable`).

## Test plan
- Basic start, `PRIME_CYCLES`=4, `ext_sync_en`=0, `link_ready`=1, `arm` at cycle 10 → one `dac_sync` pulse at cycle 12; `tx_enable` rises at cycle 17; `state` reads 4.
- External sync: `ext_sync_en`=1, `arm` at cycle 10, `ext_sync_in` held high from before arm, then falls and rises again at cycle 30 → no `dac_sync` before cycle 31; pulse at 31; RUN at 36.
- Underflow:
  - `UNF_LIMIT`=8; in RUN drive `dac_dunf` as 7 ones, one zero, then 8 ones → `unf_count`=15, HALT entered on the 8th consecutive one, `tx_enable`=0.
  - Then `arm` → `unf_count`=0, back to ARMED.
- Link loss: drop `link_ready` for one cycle during PRIME → IDLE, `link_lost`=1, no `tx_enable` pulse. A later `arm` clears `link_lost`.
- Priority: `stop` and `arm` together in IDLE → stays IDLE. `stop` and `arm` together in HALT → IDLE.
- Mid-run reset: assert `reset` for one cycle in RUN with `unf_count`=3 → next cycle state=0, `tx_enable`=0, `unf_count`=0. Also check saturation: 65540 underflow cycles with `UNF_LIMIT`=255 and the `dac_dunf` pattern broken every 200 cycles → `unf_count`=65535.
